step_sched: RTL and testbench

STEP_SCHED -- requirements
Module: step_sched

---
 rtl/step_sched.sv | 128 ++++++++++++
 tb/tb_step_sched.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/step_sched.sv
// Round-robin scheduler that shares one shift/scale stage among NREQ requesters.
// Define STEP_SCHED_ROUND_EN to round to nearest instead of truncating.
module step_sched #(
  parameter int NREQ = 4,
  parameter int DW   = 14
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ*3-1:0]  req_shift,
  output logic [NREQ-1:0]    req_ready,
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  output logic [2:0]         out_id,
  input  logic               out_ready,
  output logic [15:0]        op_count
);

  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  logic [2:0]      rr_ptr_q, rr_ptr_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [2:0]      out_id_q, out_id_d;
  logic [15:0]     op_count_q, op_count_d;

  logic [2:0]      cand [NREQ];
  logic [NREQ-1:0] valid_rot;
  logic [NREQ-1:0] grant_oh;
  logic            grant_found;
  logic [2:0]      grant_idx;
  logic            stage_free;
  logic            accept;
  logic [DW-1:0]   sel_data;
  logic [2:0]      sel_shift;
  logic [DW-1:0]   result;

  // Candidate at offset gi from the round-robin pointer, wrapped into 0..NREQ-1.
  genvar gi;
  for (gi = 0; gi < NREQ; gi++) begin : g_rot
    logic [3:0] sum;
    assign sum           = {1'b0, rr_ptr_q} + 4'(gi);
    assign cand[gi]      = (sum >= 4'(NREQ)) ? 3'(sum - 4'(NREQ)) : sum[2:0];
    assign valid_rot[gi] = |(req_valid & (ONE_HOT0 << cand[gi]));
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 3'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        grant_found = 1'b1;
        grant_idx   = cand[k];
      end
    end
  end

  assign stage_free = !out_valid_q || out_ready;
  assign accept     = rstn && stage_free && grant_found;

  for (gi = 0; gi < NREQ; gi++) begin : g_grant
    assign grant_oh[gi] = accept && (grant_idx == 3'(gi));
  end
  assign req_ready = grant_oh;

  always_comb begin
    sel_data  = '0;
    sel_shift = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_oh[i]) begin
        sel_data  = sel_data  | req_data[i*DW +: DW];
        sel_shift = sel_shift | req_shift[i*3 +: 3];
      end
    end
  end

`ifdef STEP_SCHED_ROUND_EN
  // Bias is half an LSB of the shifted result; (1<<0)>>1 gives zero bias for shift 0.
  localparam logic [DW:0] ONE_W = {{DW{1'b0}}, 1'b1};
  logic [DW:0] round_sum;
  logic [DW:0] round_shr;
  assign round_sum = {1'b0, sel_data} + ((ONE_W << sel_shift) >> 1);
  assign round_shr = round_sum >> sel_shift;
  assign result    = round_shr[DW] ? '1 : round_shr[DW-1:0];
`else
  assign result = sel_data >> sel_shift;
`endif

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    op_count_d  = op_count_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = result;
      out_id_d    = grant_idx;
      rr_ptr_d    = (4'({1'b0, grant_idx}) + 4'd1 == 4'(NREQ)) ? 3'd0 : grant_idx + 3'd1;
      op_count_d  = (op_count_q == 16'hFFFF) ? op_count_q : op_count_q + 16'd1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q    <= 3'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= 3'd0;
      op_count_q  <= 16'd0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      op_count_q  <= op_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_step_sched.sv
// Self-checking bench for step_sched: vector table plus hand sequences, results via a scoreboard queue.
module tb_step_sched;
  localparam int NREQ = 4;
  localparam int DW   = 14;

  logic               clk = 1'b0;
  logic               rstn;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ*3-1:0]  req_shift;
  logic [NREQ-1:0]    req_ready;
  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic [2:0]         out_id;
  logic               out_ready;
  logic [15:0]        op_count;

  always #5 clk = ~clk;

  step_sched #(.NREQ(NREQ), .DW(DW)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_data(req_data), .req_shift(req_shift),
    .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .out_ready(out_ready), .op_count(op_count)
  );

  typedef struct {
    logic [3:0]  v;
    logic [13:0] d;
    logic [2:0]  s;
    logic        ordy;
    logic [3:0]  rdy;
  } vec_t;

  typedef struct {
    logic [13:0] data;
    logic [2:0]  id;
  } res_t;

  vec_t        tbl [16];
  res_t        sb [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        m_valid;
  logic [15:0] m_cnt;
  bit          verbose = 1'b1;

  function automatic logic [13:0] exp_shr(logic [13:0] d, logic [2:0] s);
`ifdef STEP_SCHED_ROUND_EN
    logic [14:0] t;
    if (s == 3'd0) return d;
    t = ({1'b0, d} + (15'd1 << (s - 3'd1))) >> s;
    return t[14] ? 14'h3FFF : t[13:0];
`else
    return d >> s;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, check 1 ns later, then advance to the next falling edge.
  task automatic step(input logic [3:0] v, input logic [13:0] d, input logic [2:0] s,
                      input logic ordy, input logic [3:0] exp_rdy);
    logic [13:0] dd [NREQ];
    logic [2:0]  ss [NREQ];
    res_t        r;
    int          g;
    for (int i = 0; i < NREQ; i++) begin
      dd[i] = d ^ (14'(i) * 14'h0555);
      ss[i] = s + 3'(i);
      req_data[i*DW +: DW] = dd[i];
      req_shift[i*3 +: 3]  = ss[i];
    end
    req_valid = v;
    out_ready = ordy;
    #1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("op_count", 32'(op_count), 32'(m_cnt));
    if (m_valid && ordy) begin
      if (sb.size() == 0) begin
        check("scoreboard_empty", 32'(1), 32'(0));
      end else begin
        r = sb.pop_front();
        check("out_data", 32'(out_data), 32'(r.data));
        check("out_id", 32'(out_id), 32'(r.id));
        if (verbose) $display("txn: id=%0d data=%h count=%0d", out_id, out_data, op_count);
      end
    end
    g = -1;
    for (int i = 0; i < NREQ; i++) if (exp_rdy[i]) g = i;
    if (g >= 0) sb.push_back('{exp_shr(dd[g], ss[g]), 3'(g)});
    @(posedge clk);
    if (g >= 0) begin
      m_valid = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{4'b0000, 14'h0123, 3'd0, 1'b1, 4'b0000};
    tbl[1]  = '{4'b0010, 14'h1ABC, 3'd3, 1'b1, 4'b0010};
    tbl[2]  = '{4'b1111, 14'h3FFF, 3'd7, 1'b1, 4'b0100};
    tbl[3]  = '{4'b1111, 14'h2A5A, 3'd1, 1'b0, 4'b0000};
    tbl[4]  = '{4'b1111, 14'h0F0F, 3'd2, 1'b0, 4'b0000};
    tbl[5]  = '{4'b1111, 14'h3C3C, 3'd4, 1'b1, 4'b1000};
    tbl[6]  = '{4'b0001, 14'h0001, 3'd0, 1'b1, 4'b0001};
    tbl[7]  = '{4'b0001, 14'h2000, 3'd5, 1'b1, 4'b0001};
    tbl[8]  = '{4'b1001, 14'h1234, 3'd6, 1'b1, 4'b1000};
    tbl[9]  = '{4'b0110, 14'h0FFF, 3'd3, 1'b1, 4'b0010};
    tbl[10] = '{4'b0000, 14'h0000, 3'd0, 1'b1, 4'b0000};
    tbl[11] = '{4'b0000, 14'h0000, 3'd0, 1'b0, 4'b0000};
    tbl[12] = '{4'b0100, 14'h3333, 3'd2, 1'b0, 4'b0100};
    tbl[13] = '{4'b0100, 14'h3333, 3'd2, 1'b0, 4'b0000};
    tbl[14] = '{4'b0100, 14'h3333, 3'd2, 1'b1, 4'b0100};
    tbl[15] = '{4'b1111, 14'h2222, 3'd1, 1'b1, 4'b1000};

    // Reset state with requests already pending.
    rstn      = 1'b0;
    req_valid = 4'b1111;
    req_data  = '1;
    req_shift = '0;
    out_ready = 1'b1;
    m_valid   = 1'b0;
    m_cnt     = 16'd0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_out_id", 32'(out_id), 32'(0));
    check("rst_op_count", 32'(op_count), 32'(0));
    check("rst_req_ready", 32'(req_ready), 32'(0));
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 16; i++) step(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].ordy, tbl[i].rdy);

    // All requesting with the pointer at 0: grants rotate 0,1,2,3,0.
    for (int k = 0; k < 5; k++) step(4'b1111, 14'(14'h0101 * k), 3'(k), 1'b1, 4'(1 << (k % 4)));

    // Requester 1 gets 0x1ABC with shift 1.
    step(4'b0010, 14'h1FE9, 3'd0, 1'b1, 4'b0010);
    check("single_out_data", 32'(out_data), 32'h0D5E);
    check("single_out_id", 32'(out_id), 32'(1));

    step(4'b0001, 14'h0007, 3'd2, 1'b1, 4'b0001);
`ifdef STEP_SCHED_ROUND_EN
    check("round_7_s2", 32'(out_data), 32'(2));
`else
    check("round_7_s2", 32'(out_data), 32'(1));
`endif
    step(4'b0001, 14'h3FFF, 3'd1, 1'b1, 4'b0001);
`ifdef STEP_SCHED_ROUND_EN
    check("round_3fff_s1", 32'(out_data), 32'h2000);
`else
    check("round_3fff_s1", 32'(out_data), 32'h1FFF);
`endif

    // Leave a result pending with the pointer at 2, then reset mid-operation.
    step(4'b0010, 14'h0444, 3'd2, 1'b1, 4'b0010);
    step(4'b0000, 14'h0000, 3'd0, 1'b0, 4'b0000);
    req_valid = 4'b1111;
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_op_count", 32'(op_count), 32'(0));
    check("midrst_req_ready", 32'(req_ready), 32'(0));
    sb.delete();
    m_valid = 1'b0;
    m_cnt   = 16'd0;
    @(negedge clk);
    rstn = 1'b1;
    step(4'b1111, 14'h0AAA, 3'd0, 1'b1, 4'b0001);
    check("post_rst_id", 32'(out_id), 32'(0));

    // Drive the counter up to 65534, then into saturation.
    verbose = 1'b0;
    while (m_cnt < 16'd65534) step(4'b0001, 14'h0055, 3'd1, 1'b1, 4'b0001);
    verbose = 1'b1;
    step(4'b0000, 14'h0000, 3'd0, 1'b1, 4'b0000);
    check("cnt_preload", 32'(op_count), 32'd65534);
    for (int k = 0; k < 3; k++) step(4'b0001, 14'(k), 3'd0, 1'b1, 4'b0001);
    check("cnt_sat", 32'(op_count), 32'hFFFF);
    step(4'b0001, 14'h0100, 3'd0, 1'b1, 4'b0001);
    step(4'b0000, 14'h0000, 3'd0, 1'b1, 4'b0000);
    check("cnt_hold", 32'(op_count), 32'hFFFF);
    check("sb_drained", 32'(sb.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
